// File: rtl/adaptive_step_ctrl_if.sv
// Bundles the step controller's command, memory-read and result signals.
// master = controller side, slave = the environment (sequencer plus memory).
interface adaptive_step_ctrl_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 16
);
  logic          init;
  logic          start;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rdata_a;
  logic [W-1:0]  mem_rdata_b;
  logic          cfg_valid;
  logic          busy;
  logic          done;
  logic          proceed;
  logic          step_fail;
  logic [W-1:0]  step;
  logic [W-1:0]  error;

  modport master (
    input  init, start, mem_rdata_a, mem_rdata_b,
    output mem_rd, mem_addr, cfg_valid, busy, done, proceed, step_fail, step, error
  );

  modport slave (
    output init, start, mem_rdata_a, mem_rdata_b,
    input  mem_rd, mem_addr, cfg_valid, busy, done, proceed, step_fail, step, error
  );
endinterface

// File: rtl/adaptive_step_ctrl.sv
// Adaptive ODE step-size controller: loads N/tol/h, forms a saturating L1 error norm and
// accepts or halves the step. Define STEP_GROW_EN to also double h on very small error.
module adaptive_step_ctrl #(
  parameter int unsigned   W          = 32,
  parameter int unsigned   AW         = 16,
  parameter int unsigned   N_MAX      = 256,
  parameter int unsigned   CFG_BASE   = 0,
  parameter int unsigned   X_BASE     = 16,
  parameter logic [W-1:0]  H_MIN      = W'(1),
  parameter logic [W-1:0]  H_MAX      = {1'b1, {(W-1){1'b0}}},
  parameter int unsigned   GROW_SHIFT = 4
) (
  input logic                 clk,
  input logic                 rst,
  adaptive_step_ctrl_if.master bus
);

  localparam int unsigned CW = $clog2(N_MAX + 1);

  typedef enum logic [3:0] {
    StIdle, StCfgN, StCfgT, StCfgH, StCfgWait, StReady, StRun, StDrain, StDecide, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] n_q, idx_q;
  logic [W-1:0]  tol_q, h_q, acc_q, err_q;
  logic          cfg_valid_q, done_q, proceed_q, fail_q, ret_q;

  logic init_ok, start_ok;
  assign init_ok  = bus.init && (state_q inside {StIdle, StReady, StDone});
  assign start_ok = bus.start && !bus.init && (state_q inside {StReady, StDone});

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StReady, StDone: begin
        if (init_ok)       state_d = StCfgN;
        else if (start_ok) state_d = (n_q == '0) ? StDecide : StRun;
      end
      StCfgN:    state_d = StCfgT;
      StCfgT:    state_d = StCfgH;
      StCfgH:    state_d = StCfgWait;
      StCfgWait: state_d = StReady;
      StRun:     if (idx_q == n_q - CW'(1)) state_d = StDrain;
      StDrain:   state_d = StDecide;
      StDecide:  state_d = StDone;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.mem_rd   = 1'b0;
    bus.mem_addr = '0;
    case (state_q)
      StCfgN: begin bus.mem_rd = 1'b1; bus.mem_addr = AW'(CFG_BASE);     end
      StCfgT: begin bus.mem_rd = 1'b1; bus.mem_addr = AW'(CFG_BASE + 1); end
      StCfgH: begin bus.mem_rd = 1'b1; bus.mem_addr = AW'(CFG_BASE + 2); end
      StRun:  begin bus.mem_rd = 1'b1; bus.mem_addr = AW'(X_BASE) + AW'(idx_q); end
      default: ;
    endcase
  end

  // |a-b| at W+1 bits, then saturating accumulate
  logic signed [W:0] diff;
  logic [W:0]        mag, sum;
  logic [W-1:0]      mag_sat, acc_next;
  always_comb begin
    diff     = $signed({bus.mem_rdata_a[W-1], bus.mem_rdata_a})
             - $signed({bus.mem_rdata_b[W-1], bus.mem_rdata_b});
    mag      = diff[W] ? $unsigned(-diff) : $unsigned(diff);
    mag_sat  = mag[W] ? '1 : mag[W-1:0];
    sum      = {1'b0, acc_q} + {1'b0, mag_sat};
    acc_next = sum[W] ? '1 : sum[W-1:0];
  end

  logic [W-1:0] h_half, h_shrunk, h_accept, h_load;
  assign h_half   = h_q >> 1;
  assign h_shrunk = (h_half < H_MIN) ? H_MIN : h_half;
  assign h_load   = (bus.mem_rdata_a < H_MIN) ? H_MIN :
                    (bus.mem_rdata_a > H_MAX) ? H_MAX : bus.mem_rdata_a;

`ifdef STEP_GROW_EN
  logic [W:0] h_dbl;
  assign h_dbl    = {h_q, 1'b0};
  assign h_accept = (acc_q < (tol_q >> GROW_SHIFT)) ?
                    ((h_dbl > {1'b0, H_MAX}) ? H_MAX : h_dbl[W-1:0]) : h_q;
`else
  assign h_accept = h_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q         <= '0;
      idx_q       <= '0;
      tol_q       <= '0;
      h_q         <= '0;
      acc_q       <= '0;
      err_q       <= '0;
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      proceed_q   <= 1'b0;
      fail_q      <= 1'b0;
      ret_q       <= 1'b0;
    end else begin
      ret_q <= (state_q == StRun);
      if (ret_q) acc_q <= acc_next;
      case (state_q)
        StIdle, StReady, StDone: begin
          if (init_ok || start_ok) begin
            done_q    <= 1'b0;
            proceed_q <= 1'b0;
            fail_q    <= 1'b0;
          end
          if (start_ok) begin
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        StCfgT:    n_q   <= (bus.mem_rdata_a > W'(N_MAX)) ? CW'(N_MAX) : bus.mem_rdata_a[CW-1:0];
        StCfgH:    tol_q <= bus.mem_rdata_a;
        StCfgWait: begin
          h_q         <= h_load;
          cfg_valid_q <= 1'b1;
        end
        StRun:     idx_q <= idx_q + CW'(1);
        StDecide: begin
          err_q  <= acc_q;
          done_q <= 1'b1;
          if (acc_q <= tol_q) begin
            proceed_q <= 1'b1;
            h_q       <= h_accept;
          end else if (h_q > H_MIN) begin
            h_q <= h_shrunk;
          end else begin
            fail_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cfg_valid = cfg_valid_q;
  assign bus.busy      = !(state_q inside {StIdle, StReady, StDone});
  assign bus.done      = done_q;
  assign bus.proceed   = proceed_q;
  assign bus.step_fail = fail_q;
  assign bus.step      = h_q;
  assign bus.error     = err_q;

endmodule

// File: tb/tb_adaptive_step_ctrl.sv
// Self-checking bench for adaptive_step_ctrl: directed scenarios plus randomized evaluations
// checked against an arithmetic model of the error norm and step decision.
module tb_adaptive_step_ctrl;

  localparam longint MAXU = 64'hFFFF_FFFF;
  localparam longint HMAX = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adaptive_step_ctrl_if #(.W(32), .AW(16)) bus ();
  adaptive_step_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem_a [0:511];
  logic [31:0] mem_b [0:511];
  logic [15:0] rd_log [$];

  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_rdata_a <= mem_a[bus.mem_addr[8:0]];
      bus.mem_rdata_b <= mem_b[bus.mem_addr[8:0]];
      rd_log.push_back(bus.mem_addr);
    end
  end

  int checks = 0;
  int errors = 0;

  int unsigned m_n;
  logic [31:0] m_tol, m_h;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_pair(input int i, input logic [31:0] a, input logic [31:0] b);
    mem_a[16+i] = a;
    mem_b[16+i] = b;
  endtask

  task automatic do_init(input logic [31:0] n, input logic [31:0] tol, input logic [31:0] h);
    int cnt;
    mem_a[0] = n; mem_a[1] = tol; mem_a[2] = h;
    @(negedge clk) bus.init = 1'b1;
    @(negedge clk) bus.init = 1'b0;
    cnt = 1;
    while (bus.busy && cnt < 20) begin @(negedge clk); cnt++; end
    m_n   = (n > 256) ? 256 : n;
    m_tol = tol;
    m_h   = (h < 1) ? 32'd1 : (longint'(h) > HMAX) ? 32'h8000_0000 : h;
    checks++;
    if (cnt !== 5 || bus.cfg_valid !== 1'b1) begin
      errors++;
      $display("FAIL init_timing: cycles=%0d cfg_valid=%b, required 5 and 1", cnt, bus.cfg_valid);
    end
    checks++;
    if (bus.step !== m_h) begin
      errors++;
      $display("FAIL init_step: got %0h required %0h", bus.step, m_h);
    end
    checks++;
    if ({bus.done, bus.proceed, bus.step_fail} !== 3'b000) begin
      errors++;
      $display("FAIL init_clear: done/proceed/fail=%b required 000",
               {bus.done, bus.proceed, bus.step_fail});
    end
  endtask

  // One start/evaluation; poke re-issues start and init while the block is busy
  task automatic run_eval(input string name, input bit poke);
    longint sum, d;
    logic [31:0] e_err, e_h;
    bit e_pro, e_fail;
    int cnt, exp_cyc, bad;
    sum = 0;
    for (int i = 0; i < int'(m_n); i++) begin
      d = longint'($signed(mem_a[16+i])) - longint'($signed(mem_b[16+i]));
      if (d < 0) d = -d;
      if (d > MAXU) d = MAXU;
      sum += d;
      if (sum > MAXU) sum = MAXU;
    end
    e_err  = sum[31:0];
    e_pro  = (e_err <= m_tol);
    e_fail = 1'b0;
    e_h    = m_h;
    if (e_pro) begin
`ifdef STEP_GROW_EN
      if (e_err < (m_tol >> 4)) e_h = (longint'(m_h) * 2 > HMAX) ? 32'h8000_0000 : (m_h << 1);
`endif
    end else if (m_h > 1) begin
      e_h = m_h >> 1;
      if (e_h < 1) e_h = 1;
    end else begin
      e_fail = 1'b1;
    end
    exp_cyc = (m_n == 0) ? 2 : int'(m_n) + 3;

    rd_log.delete();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    cnt = 1;
    while (!bus.done && cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (poke && cnt == 2) begin bus.start = 1'b1; bus.init = 1'b1; end
      if (poke && cnt == 3) begin bus.start = 1'b0; bus.init = 1'b0; end
    end
    bus.start = 1'b0; bus.init = 1'b0;

    checks++;
    if (cnt !== exp_cyc) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d required %0d", name, cnt, exp_cyc);
    end
    checks++;
    if (bus.error !== e_err) begin
      errors++;
      $display("FAIL %s error: got %0h required %0h", name, bus.error, e_err);
    end
    checks++;
    if (bus.proceed !== e_pro || bus.step_fail !== e_fail) begin
      errors++;
      $display("FAIL %s decision: proceed=%b fail=%b required %b %b", name, bus.proceed,
               bus.step_fail, e_pro, e_fail);
    end
    checks++;
    if (bus.step !== e_h) begin
      errors++;
      $display("FAIL %s step: got %0h required %0h", name, bus.step, e_h);
    end
    bad = (rd_log.size() != int'(m_n)) ? 1 : 0;
    for (int i = 0; i < rd_log.size() && i < int'(m_n); i++)
      if (rd_log[i] !== 16'(16 + i)) bad++;
    checks++;
    if (bad != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s reads: count=%0d required %0d, bad=%0d busy=%b", name, rd_log.size(),
               m_n, bad, bus.busy);
    end
    m_h = e_h;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_rd, bus.busy, bus.cfg_valid, bus.done, bus.proceed, bus.step_fail} !== 6'b0 ||
        bus.step !== 32'd0 || bus.error !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: flags=%b step=%0h error=%0h required all zero",
               {bus.mem_rd, bus.busy, bus.cfg_valid, bus.done, bus.proceed, bus.step_fail},
               bus.step, bus.error);
    end
    rst = 1'b0;
  endtask

  task automatic test_start_before_init;
    int hits = 0;
    rd_log.delete();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (4) begin
      if (bus.busy || bus.done) hits++;
      @(negedge clk);
    end
    checks++;
    if (hits != 0 || rd_log.size() != 0) begin
      errors++;
      $display("FAIL start_no_cfg: busy/done cycles=%0d reads=%0d required 0 0", hits,
               rd_log.size());
    end
  endtask

  task automatic test_accept;
    do_init(4, 100, 64);
    set_pair(0, 32'd110, 32'd100);
    set_pair(1, 32'hFFFF_FFF6, 32'd10);   // -10 - 10 = -20
    set_pair(2, 32'd30, 32'd0);
    set_pair(3, 32'd0, 32'd5);
    run_eval("accept", 1'b0);
    checks++;
    if (bus.error !== 32'd65 || bus.proceed !== 1'b1 || bus.step !== 32'd64) begin
      errors++;
      $display("FAIL accept_const: error=%0d proceed=%b step=%0d required 65 1 64", bus.error,
               bus.proceed, bus.step);
    end
  endtask

  task automatic test_reject;
    do_init(4, 100, 64);
    for (int i = 0; i < 4; i++) set_pair(i, 32'd50, 32'd0);
    run_eval("reject1", 1'b0);
    checks++;
    if (bus.error !== 32'd200 || bus.step !== 32'd32 || bus.step_fail !== 1'b0) begin
      errors++;
      $display("FAIL reject_const: error=%0d step=%0d fail=%b required 200 32 0", bus.error,
               bus.step, bus.step_fail);
    end
    run_eval("reject2", 1'b0);
    checks++;
    if (bus.step !== 32'd16) begin
      errors++;
      $display("FAIL reject_again: step=%0d required 16", bus.step);
    end
  endtask

  task automatic test_floor;
    do_init(4, 100, 1);
    run_eval("floor", 1'b0);
    checks++;
    if (bus.step_fail !== 1'b1 || bus.proceed !== 1'b0 || bus.step !== 32'd1) begin
      errors++;
      $display("FAIL floor_const: fail=%b proceed=%b step=%0d required 1 0 1", bus.step_fail,
               bus.proceed, bus.step);
    end
  endtask

  task automatic test_saturation;
    do_init(2, 100, 64);
    set_pair(0, 32'h7FFF_FFFF, 32'h8000_0000);
    set_pair(1, 32'h7FFF_FFFF, 32'h8000_0000);
    run_eval("saturate", 1'b0);
    checks++;
    if (bus.error !== 32'hFFFF_FFFF || bus.proceed !== 1'b0) begin
      errors++;
      $display("FAIL saturate_const: error=%0h proceed=%b required ffffffff 0", bus.error,
               bus.proceed);
    end
  endtask

  task automatic test_growth;
    logic [31:0] want;
`ifdef STEP_GROW_EN
    want = 32'd128;
`else
    want = 32'd64;
`endif
    do_init(4, 100, 64);
    for (int i = 0; i < 4; i++) set_pair(i, 32'd7, 32'd6);
    run_eval("grow", 1'b0);
    checks++;
    if (bus.error !== 32'd4 || bus.proceed !== 1'b1 || bus.step !== want) begin
      errors++;
      $display("FAIL grow_const: error=%0d proceed=%b step=%0d required 4 1 %0d", bus.error,
               bus.proceed, bus.step, want);
    end
    do_init(4, 100, 32'hFFFF_FFFF);       // clamps to H_MAX
    run_eval("grow_hmax", 1'b0);
    checks++;
    if (bus.step !== 32'h8000_0000) begin
      errors++;
      $display("FAIL grow_hmax: step=%0h required 80000000", bus.step);
    end
  endtask

  task automatic test_control;
    do_init(6, 1000, 40);
    for (int i = 0; i < 6; i++) set_pair(i, $urandom_range(0, 300), $urandom_range(0, 300));
    run_eval("busy_ignore", 1'b1);
    do_init(0, 5, 0);
    run_eval("n_zero", 1'b0);
    checks++;
    if (bus.error !== 32'd0 || bus.proceed !== 1'b1) begin
      errors++;
      $display("FAIL n_zero_const: error=%0d proceed=%b required 0 1", bus.error, bus.proceed);
    end
    do_init(300, 32'hFFFF_FFFF, 8);
    for (int i = 0; i < 256; i++) set_pair(i, $urandom, $urandom);
    run_eval("n_clamp", 1'b0);
    // reset in the middle of RUN
    do_init(8, 100, 64);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_rd !== 1'b0 || bus.step !== 32'd0 || bus.cfg_valid !== 1'b0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_run: mem_rd=%b step=%0h cfg_valid=%b busy=%b required 0 0 0 0",
               bus.mem_rd, bus.step, bus.cfg_valid, bus.busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] a;
    int n;
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 12);
      case ($urandom_range(0, 3))
        0:       do_init(n, $urandom_range(0, 3000), $urandom);
        1:       do_init(n, $urandom_range(0, 3000), 0);
        default: do_init(n, $urandom_range(0, 3000), $urandom_range(1, 1024));
      endcase
      for (int i = 0; i < n; i++) begin
        a = $urandom;
        if ($urandom_range(0, 3) == 0) set_pair(i, a, $urandom);
        else set_pair(i, a, a + 32'($urandom_range(0, 400)) - 32'd200);
      end
      run_eval("random", 1'b0);
      if ($urandom_range(0, 1) == 1) run_eval("random_rerun", 1'b0);
    end
  endtask

  initial begin
    bus.init  = 1'b0;
    bus.start = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 512; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    test_reset;
    test_start_before_init;
    test_accept;
    test_reject;
    test_floor;
    test_saturation;
    test_growth;
    test_control;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adaptive_step_ctrl.md
Name: adaptive_step_ctrl

Overview:
- Parametrised next-generation step-size controller for the ODE solver datapath.
- Loads N, tolerance and initial step h from a config area, then on each `start` streams N pairs of solution estimates from memory.
- Forms a saturating L1 error norm in a pipelined pass and accepts or rejects the step.
- On rejection it halves h, clamped at H_MIN. Optionally it doubles h on very small error, clamped at H_MAX.

Parameters:
W, 32, data width of estimates, tolerance, step and error (unsigned except estimates)
AW, 16, memory address width
N_MAX, 256, maximum vector length; loaded N above this is clamped to N_MAX
CFG_BASE, 0, address of N; tolerance at CFG_BASE+1, h at CFG_BASE+2
X_BASE, 16, address of element 0 of the estimate vectors
H_MIN, 1, smallest legal step
H_MAX, 2**(W-1), largest legal step
GROW_SHIFT, 4, growth threshold is tol >> GROW_SHIFT

Ports:
clk  in  1  clock
rst  in  1  reset
init  in  1  request config load
start  in  1  request one error/step evaluation
mem_rd  out  1  memory read strobe
mem_addr  out  AW  read address
mem_rdata_a  in  W  signed estimate A (or config word), valid 1 cycle after mem_rd
mem_rdata_b  in  W  signed estimate B, valid 1 cycle after mem_rd
cfg_valid  out  1  config loaded
busy  out  1  high in every state except IDLE/READY/DONE
done  out  1  evaluation result valid (level)
proceed  out  1  step accepted
step_fail  out  1  rejection with h already at H_MIN
step  out  W  current step size
error  out  W  last error norm

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All outputs and internal registers go to 0 and state goes to IDLE, including mid-operation.
  - mem_rd is low on the cycle after rst is sampled.
- States: IDLE, CFG_N, CFG_T, CFG_H, CFG_WAIT, READY, RUN, DRAIN, DECIDE, DONE.
- Accepting init and start:
  - init is accepted only in IDLE, READY or DONE, and has priority over start.
  - start is accepted only in READY or DONE. start in IDLE (no config) is ignored.
  - init or start while busy is ignored.
- Config load: CFG_N → CFG_T → CFG_H → CFG_WAIT → READY.
  - Each CFG state issues mem_rd at CFG_BASE+0/1/2.
  - Data is captured from mem_rdata_a one cycle later: N in CFG_T, tol in CFG_H, h in CFG_WAIT.
  - h is clamped into [H_MIN, H_MAX].
  - cfg_valid is set on entering READY and stays set until rst.
  - Re-init from DONE clears done, proceed and step_fail.
- start accepted (cycle 0):
  - Accumulator, done, proceed and step_fail clear.
  - If N=0, go straight to DECIDE.
  - Otherwise RUN issues mem_rd at X_BASE+i for i=0..N-1, one read per cycle, on cycles 1..N.
  - DRAIN (cycle N+1) absorbs the last return. DECIDE is on cycle N+2. done rises on cycle N+3 (cycle 2 when N=0).
- Accumulation: every return cycle adds |a−b| to the accumulator.
  - The difference is computed at W+1 bits and the magnitude saturates to 2^W−1.
  - The sum saturates at 2^W−1, never wrapping.
- DECIDE (registers error):
  - error ≤ tol: proceed=1. Growth applies under the macro only.
  - error > tol and h > H_MIN: h = max(h>>1, H_MIN), proceed=0.
  - error > tol and h = H_MIN: step_fail=1, proceed=0, h unchanged.
- DONE: done=1, outputs held stable until the next accepted start or init.

Optional Feature:
- Macro: STEP_GROW_EN.
- Defined: in DECIDE, if error < (tol >> GROW_SHIFT) and proceed=1, then h = min(h<<1, H_MAX), computed at W+1 bits before the clamp.
- Undefined: h is never increased on acceptance. Logic is absent.

Test Plan:
- Config + accept: init with N=4, tol=100, h=64; diffs 10,−20,30,−5 → cfg_valid=1 and done on cycle 7 after start; error=65, proceed=1, step=64 (not grown, since 65 ≥ 6).
- Reject: same config, diffs 50,50,50,50 → error=200, proceed=0, step_fail=0, step=32; a second start with identical data gives step=16.
- Floor: H_MIN=1, h=1, error > tol → step_fail=1, proceed=0, step=1.
- Saturation: N=2, a=0x7FFFFFFF, b=0x80000000 twice → error=0xFFFFFFFF, proceed=0.
- Growth (STEP_GROW_EN): diffs 1,1,1,1, tol=100 → error=4, proceed=1, step=128. Without the macro → step=64. With h=H_MAX → step stays at H_MAX.
- Control: rst during RUN → next cycle mem_rd=0, step=0, cfg_valid=0, state IDLE. start before init is ignored. start while busy is ignored. N=0 → done on cycle 2, error=0, proceed=1.
